// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: control from decode/branch, instruction memory handshake
// and the registered decode-facing output buffer.
interface fetch_unit_if;
  logic        Stall;
  logic        Redirect;
  logic [31:0] Redirect_PC;
  logic        IMem_Req;
  logic [31:0] IMem_Addr;
  logic        IMem_Ack;
  logic [31:0] IMem_Data;
  logic        Valid_Out;
  logic [31:0] Instr_Out;
  logic [31:0] PC_Plus_4_Out;

  modport master (
    input  Stall, Redirect, Redirect_PC, IMem_Ack, IMem_Data,
    output IMem_Req, IMem_Addr, Valid_Out, Instr_Out, PC_Plus_4_Out
  );

  modport slave (
    output Stall, Redirect, Redirect_PC, IMem_Ack, IMem_Data,
    input  IMem_Req, IMem_Addr, Valid_Out, Instr_Out, PC_Plus_4_Out
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding memory request, one-entry output buffer
// plus one-entry skid so a zero-wait stream survives a decode stall without loss.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          CLK,
  input  logic          RST,
  fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_addr;
  logic        req_q;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc4;
  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc4;

  logic        ack;
  logic        consume;
  logic [31:0] target;
  logic [31:0] next_addr;

  // Request is registered and held low through reset, so an Ack is only honoured
  // once a request has actually been presented.
  assign ack       = bus.IMem_Ack & req_q;
  assign consume   = out_valid & ~bus.Stall;
  assign target    = bus.Redirect_PC & ~32'h3;
  assign next_addr = req_addr + 32'd4;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      req_addr   <= RESET_PC;
      req_q      <= 1'b0;
      out_valid  <= 1'b0;
      out_instr  <= '0;
      out_pc4    <= '0;
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc4   <= '0;
    end else begin
      req_q <= 1'b1;
      if (bus.Redirect) begin
        out_valid  <= 1'b0;
        out_instr  <= '0;
        out_pc4    <= '0;
        skid_valid <= 1'b0;
        skid_instr <= '0;
        skid_pc4   <= '0;
        pc         <= target;
      end
      unique case (state)
        FETCH: begin
          if (bus.Redirect) begin
            if (ack) begin
              req_addr <= target;
            end else begin
              state <= DISCARD;
            end
          end else if (ack) begin
            pc <= next_addr;
            if (!out_valid || consume) begin
              out_valid <= 1'b1;
              out_instr <= bus.IMem_Data;
              out_pc4   <= next_addr;
              req_addr  <= next_addr;
            end else begin
              skid_valid <= 1'b1;
              skid_instr <= bus.IMem_Data;
              skid_pc4   <= next_addr;
              state      <= HOLD;
              req_q      <= 1'b0;
            end
          end else if (consume) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_pc4   <= '0;
          end
        end
        HOLD: begin
          if (bus.Redirect) begin
            req_addr <= target;
            state    <= FETCH;
          end else if (consume) begin
            out_valid  <= skid_valid;
            out_instr  <= skid_instr;
            out_pc4    <= skid_pc4;
            skid_valid <= 1'b0;
            skid_instr <= '0;
            skid_pc4   <= '0;
            req_addr   <= pc;
            state      <= FETCH;
          end else begin
            req_q <= 1'b0;
          end
        end
        DISCARD: begin
          // The stale response is swallowed here; the buffers stay empty throughout.
          if (!bus.Redirect && ack) begin
            req_addr <= pc;
            state    <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign bus.IMem_Req      = req_q;
  assign bus.IMem_Addr     = req_addr;
  assign bus.Valid_Out     = out_valid;
  assign bus.Instr_Out     = out_instr;
  assign bus.PC_Plus_4_Out = out_pc4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, wait states, stall/skid, redirects,
// async reset in HOLD, and a second instance exercising address wrap.
module tb_fetch_unit;
  logic clk;
  logic rst;
  int unsigned errors;
  int unsigned checks;

  fetch_unit_if bus ();
  fetch_unit_if wbus ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (.CLK(clk), .RST(rst), .bus(bus));
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (.CLK(clk), .RST(rst), .bus(wbus));

  assign bus.IMem_Data  = bus.IMem_Addr ^ 32'hA5A5_0000;
  assign wbus.IMem_Data = wbus.IMem_Addr ^ 32'hA5A5_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.Stall = 1'b0; bus.Redirect = 1'b0; bus.Redirect_PC = '0; bus.IMem_Ack = 1'b0;
    wbus.Stall = 1'b0; wbus.Redirect = 1'b0; wbus.Redirect_PC = '0; wbus.IMem_Ack = 1'b1;

    tick(); tick();
    chk("rst_req",   {31'd0, bus.IMem_Req},  32'd0);
    chk("rst_valid", {31'd0, bus.Valid_Out}, 32'd0);
    chk("rst_instr", bus.Instr_Out,          32'd0);
    chk("rst_pc4",   bus.PC_Plus_4_Out,      32'd0);
    chk("rst_addr",  bus.IMem_Addr,          32'd0);
    chk("rst_wreq",  {31'd0, wbus.IMem_Req}, 32'd0);

    // Release between edges; stream with Ack held high
    rst = 1'b0;
    bus.IMem_Ack = 1'b1;
    tick();
    chk("first_req",   {31'd0, bus.IMem_Req},  32'd1);
    chk("first_addr",  bus.IMem_Addr,          32'd0);
    chk("first_valid", {31'd0, bus.Valid_Out}, 32'd0);
    chk("wrap_addr0",  wbus.IMem_Addr,         32'hFFFF_FFFC);

    tick();
    chk("s1_valid", {31'd0, bus.Valid_Out}, 32'd1);
    chk("s1_pc4",   bus.PC_Plus_4_Out,      32'd4);
    chk("s1_instr", bus.Instr_Out,          32'hA5A5_0000);
    chk("wrap_pc4",   wbus.PC_Plus_4_Out,   32'h0000_0000);
    chk("wrap_instr", wbus.Instr_Out,       32'h5A5A_FFFC);
    chk("wrap_addr1", wbus.IMem_Addr,       32'h0000_0000);
    tick();
    chk("s2_pc4",   bus.PC_Plus_4_Out, 32'd8);
    chk("s2_instr", bus.Instr_Out,     32'hA5A5_0004);
    chk("wrap_pc4b", wbus.PC_Plus_4_Out, 32'h0000_0004);
    tick();
    chk("s3_pc4",   bus.PC_Plus_4_Out, 32'd12);
    chk("s3_instr", bus.Instr_Out,     32'hA5A5_0008);
    tick();
    chk("s4_valid", {31'd0, bus.Valid_Out}, 32'd1);
    chk("s4_pc4",   bus.PC_Plus_4_Out,      32'd16);
    chk("s4_addr",  bus.IMem_Addr,          32'd16);

    // Stall for 4 edges: 16 held, 20 goes into the skid, no requests in HOLD
    bus.Stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_req",   {31'd0, bus.IMem_Req},  32'd0);
      chk("hold_pc4",   bus.PC_Plus_4_Out,      32'd16);
      chk("hold_instr", bus.Instr_Out,          32'hA5A5_000C);
    end
    bus.Stall = 1'b0;
    tick();
    chk("skid_pc4",   bus.PC_Plus_4_Out,      32'd20);
    chk("skid_instr", bus.Instr_Out,          32'hA5A5_0010);
    chk("skid_req",   {31'd0, bus.IMem_Req},  32'd1);
    chk("skid_addr",  bus.IMem_Addr,          32'd20);
    tick();
    chk("after_pc4",   bus.PC_Plus_4_Out, 32'd24);
    chk("after_instr", bus.Instr_Out,     32'hA5A5_0014);

    // Wait states: request at 24 acked on the third cycle
    bus.IMem_Ack = 1'b0;
    chk("ws_addr0", bus.IMem_Addr, 32'd24);
    tick();
    chk("ws_addr1",  bus.IMem_Addr,          32'd24);
    chk("ws_valid1", {31'd0, bus.Valid_Out}, 32'd0);
    chk("ws_instr1", bus.Instr_Out,          32'd0);
    tick();
    chk("ws_addr2",  bus.IMem_Addr,          32'd24);
    chk("ws_valid2", {31'd0, bus.Valid_Out}, 32'd0);
    bus.IMem_Ack = 1'b1;
    tick();
    bus.IMem_Ack = 1'b0;
    chk("ws_valid3", {31'd0, bus.Valid_Out}, 32'd1);
    chk("ws_pc4",    bus.PC_Plus_4_Out,      32'd28);
    chk("ws_instr",  bus.Instr_Out,          32'hA5A5_0018);
    chk("ws_addr3",  bus.IMem_Addr,          32'd28);
    tick();
    chk("ws_valid4", {31'd0, bus.Valid_Out}, 32'd0);
    chk("ws_addr4",  bus.IMem_Addr,          32'd28);

    // Redirect coinciding with Ack: data dropped, new request at target
    bus.Redirect = 1'b1; bus.Redirect_PC = 32'h0000_0010; bus.IMem_Ack = 1'b1;
    tick();
    bus.Redirect = 1'b0; bus.IMem_Ack = 1'b0;
    chk("ra_valid", {31'd0, bus.Valid_Out}, 32'd0);
    chk("ra_addr",  bus.IMem_Addr,          32'h10);
    tick();
    chk("pend_addr", bus.IMem_Addr, 32'h10);

    // Redirect during a wait -> DISCARD, stale Ack from 0x10 never surfaces
    bus.Redirect = 1'b1; bus.Redirect_PC = 32'h0000_0203;
    tick();
    bus.Redirect = 1'b0; bus.IMem_Ack = 1'b1;
    chk("disc_req",   {31'd0, bus.IMem_Req},  32'd1);
    chk("disc_addr",  bus.IMem_Addr,          32'h10);
    chk("disc_valid", {31'd0, bus.Valid_Out}, 32'd0);
    tick();
    chk("disc_drop",  {31'd0, bus.Valid_Out}, 32'd0);
    chk("disc_instr", bus.Instr_Out,          32'd0);
    chk("disc_next",  bus.IMem_Addr,          32'h200);
    tick();
    chk("redir_valid", {31'd0, bus.Valid_Out}, 32'd1);
    chk("redir_pc4",   bus.PC_Plus_4_Out,      32'h204);
    chk("redir_instr", bus.Instr_Out,          32'hA5A5_0200);

    // Redirect + Ack + Stall with the buffer full
    bus.Stall = 1'b1; bus.Redirect = 1'b1; bus.Redirect_PC = 32'h0000_0300;
    tick();
    bus.Redirect = 1'b0;
    chk("sim_valid", {31'd0, bus.Valid_Out}, 32'd0);
    chk("sim_instr", bus.Instr_Out,          32'd0);
    chk("sim_pc4",   bus.PC_Plus_4_Out,      32'd0);
    chk("sim_addr",  bus.IMem_Addr,          32'h300);

    // Fill buffer then skid to reach HOLD, then pulse RST between edges
    tick();
    chk("h_pc4", bus.PC_Plus_4_Out, 32'h304);
    tick();
    chk("h_req", {31'd0, bus.IMem_Req}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", {31'd0, bus.Valid_Out}, 32'd0);
    chk("ar_instr", bus.Instr_Out,          32'd0);
    chk("ar_pc4",   bus.PC_Plus_4_Out,      32'd0);
    chk("ar_req",   {31'd0, bus.IMem_Req},  32'd0);
    #1 rst = 1'b0;
    bus.Stall = 1'b0;
    tick();
    chk("ar_rel_req",  {31'd0, bus.IMem_Req}, 32'd1);
    chk("ar_rel_addr", bus.IMem_Addr,         32'd0);
    tick();
    chk("ar_rel_pc4",  bus.PC_Plus_4_Out,     32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
